// File: rtl/juggle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : juggle_pkg
// Description : Types shared by the siteswap validator and the trajectory
//               generator: throw height, error codes and validator states.
// Revision    : 1.0 - initial release
// ============================================================================
package juggle_pkg;

  localparam int MAX_LEN_C = 7;

  typedef logic [2:0] throw_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_LEN      = 3'd1,
    ERR_NOT_INT  = 3'd2,
    ERR_ZERO     = 3'd3,
    ERR_COLLIDE  = 3'd4,
    ERR_TOO_MANY = 3'd5
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SUM    = 3'd1,
    ST_DIV    = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
`ifdef SITESWAP_ROTATE_EN
    , ST_ROTATE = 3'd6
`endif
  } state_e;

endpackage
`default_nettype wire

// File: rtl/siteswap_validator_if.sv
`default_nettype none
// ============================================================================
// Module      : siteswap_validator_if
// Description : Request/result bundle between pattern-entry logic (master)
//               and the siteswap validator (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface siteswap_validator_if import juggle_pkg::*; #(
  parameter int MAX_LEN = MAX_LEN_C
) ();

  throw_t [MAX_LEN-1:0] pattern_in;
  logic   [2:0]         len_in;
  logic                 start_in;
  logic                 busy_out;
  logic                 done_out;
  throw_t [MAX_LEN-1:0] pattern_out;
  logic   [2:0]         pattern_len_out;
  logic   [2:0]         num_balls_out;
  logic                 pattern_valid_out;
  err_e                 err_out;

  modport master (
    output pattern_in, len_in, start_in,
    input  busy_out, done_out, pattern_out, pattern_len_out,
    input  num_balls_out, pattern_valid_out, err_out
  );

  modport slave (
    input  pattern_in, len_in, start_in,
    output busy_out, done_out, pattern_out, pattern_len_out,
    output num_balls_out, pattern_valid_out, err_out
  );

endinterface
`default_nettype wire

// File: rtl/siteswap_validator_landing_mod.sv
`default_nettype none
// ============================================================================
// Module      : landing_mod
// Description : Combinational (idx + throw) mod len for idx < 7, throw < 8,
//               1 <= len <= 7. Operand is at most 13, so four conditional
//               subtractions of len*8, len*4, len*2, len reduce it fully.
// Revision    : 1.0 - initial release
// ============================================================================
module landing_mod import juggle_pkg::*; (
  input  wire logic [2:0] i_idx,
  input  wire throw_t     i_throw,
  input  wire logic [2:0] i_len,
  output logic [2:0]      o_land
);

  logic [6:0] w_val;
  logic [6:0] w_div;

  // Restoring-style reduction: each stage removes len<<k if it fits.
  always_comb begin
    w_val = {4'b0, i_idx} + {4'b0, i_throw};
    w_div = '0;
    for (int k = 3; k >= 0; k--) begin
      w_div = {4'b0, i_len} << k;
      if (w_val >= w_div) begin
        w_val = w_val - w_div;
      end
    end
  end

  assign o_land = w_val[2:0];

endmodule
`default_nettype wire

// File: rtl/siteswap_validator.sv
`default_nettype none
// ============================================================================
// Module      : siteswap_validator
// Description : Sequential siteswap juggleability check. Sums the throws,
//               divides by the period (repeated subtraction) to get the ball
//               count, then walks the landing beats through an occupancy
//               bitmap. One throw per cycle.
// Options     : SITESWAP_ROTATE_EN - rotate the emitted pattern so the first
//               highest throw is at index 0 (adds len cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module siteswap_validator import juggle_pkg::*; #(
  parameter int MAX_LEN   = 7,
  parameter int MAX_BALLS = 7
) (
  input wire logic            clk_in,
  input wire logic            rst_in,
  siteswap_validator_if.slave bus
);

  state_e               r_state;
  state_e               w_state_nxt;
  throw_t [MAX_LEN-1:0] r_pat;
  logic   [2:0]         r_len;
  logic   [2:0]         r_idx;
  logic   [5:0]         r_rem;
  logic   [5:0]         r_quot;
  logic   [MAX_LEN-1:0] r_occ;

  logic                 r_done;
  logic                 r_valid;
  err_e                 r_err;
  throw_t [MAX_LEN-1:0] r_pat_out;
  logic   [2:0]         r_len_out;
  logic   [2:0]         r_balls;

  logic                 w_accept;
  logic                 w_len_bad;
  logic                 w_last;
  logic                 w_to_done;
  logic                 w_to_error;
  err_e                 w_err_code;
  logic   [2:0]         w_land;
  throw_t [MAX_LEN-1:0] w_done_pat;

  landing_mod u_landing (
    .i_idx   (r_idx),
    .i_throw (r_pat[r_idx]),
    .i_len   (r_len),
    .o_land  (w_land)
  );

`ifdef SITESWAP_ROTATE_EN
  throw_t     r_max;
  logic [2:0] r_max_idx;
  logic [2:0] w_rot_k;
  logic [3:0] w_src;

  // Rotation amount including the throw being scanned this cycle.
  assign w_rot_k = (r_pat[r_idx] > r_max) ? r_idx : r_max_idx;

  // Rotate so the first maximum throw lands at index 0; tail stays zero.
  always_comb begin
    w_done_pat = '0;
    w_src      = '0;
    for (int j = 0; j < MAX_LEN; j++) begin
      w_src = 4'(j) + {1'b0, w_rot_k};
      if (w_src >= {1'b0, r_len}) begin
        w_src = w_src - {1'b0, r_len};
      end
      if (j < int'(r_len)) begin
        w_done_pat[j] = r_pat[w_src[2:0]];
      end
    end
  end
`else
  assign w_done_pat = r_pat;
`endif

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and completion strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_to_done   = 1'b0;
    w_to_error  = 1'b0;
    w_err_code  = ERR_NONE;
    w_len_bad   = (bus.len_in == 3'd0) || (int'(bus.len_in) > MAX_LEN);
    w_last      = (r_idx == (r_len - 3'd1));
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (bus.start_in) begin
          w_accept = 1'b1;
          if (w_len_bad) begin
            w_state_nxt = ST_ERROR;
            w_to_error  = 1'b1;
            w_err_code  = ERR_LEN;
          end else begin
            w_state_nxt = ST_SUM;
          end
        end
      end
      ST_SUM: begin
        if (w_last) begin
          w_state_nxt = ST_DIV;
        end
      end
      ST_DIV: begin
        if (r_rem < {3'b0, r_len}) begin
          if (r_rem != 6'd0) begin
            w_state_nxt = ST_ERROR;
            w_to_error  = 1'b1;
            w_err_code  = ERR_NOT_INT;
          end else if (r_quot == 6'd0) begin
            w_state_nxt = ST_ERROR;
            w_to_error  = 1'b1;
            w_err_code  = ERR_ZERO;
          end else if (int'(r_quot) > MAX_BALLS) begin
            w_state_nxt = ST_ERROR;
            w_to_error  = 1'b1;
            w_err_code  = ERR_TOO_MANY;
          end else begin
            w_state_nxt = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (r_occ[w_land]) begin
          w_state_nxt = ST_ERROR;
          w_to_error  = 1'b1;
          w_err_code  = ERR_COLLIDE;
        end else if (w_last) begin
`ifdef SITESWAP_ROTATE_EN
          w_state_nxt = ST_ROTATE;
`else
          w_state_nxt = ST_DONE;
          w_to_done   = 1'b1;
`endif
        end
      end
`ifdef SITESWAP_ROTATE_EN
      ST_ROTATE: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
          w_to_done   = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch request, accumulate, divide, mark landings, publish.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pat     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_occ     <= '0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= ERR_NONE;
      r_pat_out <= '0;
      r_len_out <= '0;
      r_balls   <= '0;
`ifdef SITESWAP_ROTATE_EN
      r_max     <= '0;
      r_max_idx <= '0;
`endif
    end else begin
      r_done <= w_to_done | w_to_error;
      if (w_accept) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          r_pat[i] <= (i < int'(bus.len_in)) ? bus.pattern_in[i] : '0;
        end
        r_len     <= bus.len_in;
        r_idx     <= '0;
        r_rem     <= '0;
        r_quot    <= '0;
        r_occ     <= '0;
        r_valid   <= 1'b0;
        r_err     <= ERR_NONE;
        r_pat_out <= '0;
      end
      case (r_state)
        ST_SUM: begin
          // The sum is accumulated straight into the remainder register.
          r_rem <= r_rem + {3'b0, r_pat[r_idx]};
          r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
        end
        ST_DIV: begin
          if (r_rem >= {3'b0, r_len}) begin
            r_rem  <= r_rem - {3'b0, r_len};
            r_quot <= r_quot + 6'd1;
          end
        end
        ST_CHECK: begin
          r_occ[w_land] <= 1'b1;
          r_idx         <= w_last ? 3'd0 : r_idx + 3'd1;
`ifdef SITESWAP_ROTATE_EN
          r_max         <= '0;
          r_max_idx     <= '0;
`endif
        end
`ifdef SITESWAP_ROTATE_EN
        ST_ROTATE: begin
          if (r_pat[r_idx] > r_max) begin
            r_max     <= r_pat[r_idx];
            r_max_idx <= r_idx;
          end
          r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
        end
`endif
        default: ;
      endcase
      if (w_to_done) begin
        r_valid   <= 1'b1;
        r_err     <= ERR_NONE;
        r_pat_out <= w_done_pat;
        r_len_out <= r_len;
        r_balls   <= r_quot[2:0];
      end
      if (w_to_error) begin
        r_valid   <= 1'b0;
        r_err     <= w_err_code;
        r_pat_out <= '0;
      end
    end
  end

  assign bus.busy_out          = (r_state == ST_SUM) || (r_state == ST_DIV) ||
`ifdef SITESWAP_ROTATE_EN
                                 (r_state == ST_ROTATE) ||
`endif
                                 (r_state == ST_CHECK);
  assign bus.done_out          = r_done;
  assign bus.pattern_out       = r_pat_out;
  assign bus.pattern_len_out   = r_len_out;
  assign bus.num_balls_out     = r_balls;
  assign bus.pattern_valid_out = r_valid;
  assign bus.err_out           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_siteswap_validator.sv
`default_nettype none
// ============================================================================
// Module      : tb_siteswap_validator
// Description : Directed self-checking bench for siteswap_validator with a
//               reference model feeding an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_siteswap_validator;
  import juggle_pkg::*;

  localparam int MAX_LEN = 7;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  siteswap_validator_if #(.MAX_LEN(MAX_LEN)) bus_if ();

  siteswap_validator #(.MAX_LEN(MAX_LEN), .MAX_BALLS(7)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_if.slave)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0]  err;
    logic        valid;
    logic [2:0]  balls;
    logic [20:0] pat;
    logic [2:0]  len;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] pack(input int p[7]);
    logic [20:0] v;
    v = '0;
    for (int i = 0; i < 7; i++) v[3*i +: 3] = 3'(p[i]);
    return v;
  endfunction

  // Reference model: arithmetic with / and %, cycle count from the latency rule.
  function automatic exp_t model(input int p[7], input int len);
    exp_t e;
    int   sum, q, r, k;
    bit   occ[7];
    e.err = ERR_NONE; e.valid = 1'b0; e.balls = '0; e.pat = '0; e.len = '0; e.lat = 0;
    if (len < 1 || len > 7) begin
      e.err = ERR_LEN;
      return e;
    end
    sum = 0;
    for (int i = 0; i < len; i++) sum += p[i];
    q = sum / len;
    r = sum % len;
    e.lat = len + q + 1;
    if (r != 0) begin e.err = ERR_NOT_INT; return e; end
    if (q == 0) begin e.err = ERR_ZERO; return e; end
    if (q > 7) begin e.err = ERR_TOO_MANY; return e; end
    for (int i = 0; i < 7; i++) occ[i] = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (occ[(i + p[i]) % len]) begin
        e.err = ERR_COLLIDE;
        e.lat = len + q + 2 + i;
        return e;
      end
      occ[(i + p[i]) % len] = 1'b1;
    end
    k = 0;
`ifdef SITESWAP_ROTATE_EN
    for (int i = 0; i < len; i++) if (p[i] > p[k]) k = i;
    e.lat = 3 * len + q + 1;
`else
    e.lat = 2 * len + q + 1;
`endif
    for (int j = 0; j < len; j++) e.pat[3*j +: 3] = 3'(p[(j + k) % len]);
    e.valid = 1'b1;
    e.balls = 3'(q);
    e.len   = 3'(len);
    return e;
  endfunction

  // Issue one request, optionally re-pulse start_in at edge `glitch`, then
  // wait for done_out and compare against the queued expectation.
  task automatic run(input string name, input int p[7], input int len, input int glitch);
    exp_t e;
    int   n;
    bit   seen, valid_low;
    @(negedge clk_in);
    bus_if.pattern_in = pack(p);
    bus_if.len_in     = 3'(len);
    bus_if.start_in   = 1'b1;
    sb_q.push_back(model(p, len));
    @(posedge clk_in); #1;
    bus_if.start_in = 1'b0;
    check({name, " busy"}, 32'(bus_if.busy_out), 32'(len >= 1 && len <= 7));
    check({name, " valid_clr"}, 32'(bus_if.pattern_valid_out), 32'd0);
    n = 0; seen = 1'b0; valid_low = 1'b1;
    while (!seen && n < 300) begin
      if (bus_if.done_out) begin
        seen = 1'b1;
      end else begin
        if (bus_if.pattern_valid_out !== 1'b0) valid_low = 1'b0;
        @(negedge clk_in);
        if (n + 1 == glitch) begin
          bus_if.start_in   = 1'b1;
          bus_if.len_in     = 3'd3;
          bus_if.pattern_in = 21'o0000234;
        end
        @(posedge clk_in); #1;
        bus_if.start_in = 1'b0;
        n++;
      end
    end
    e = sb_q.pop_front();
    check({name, " done_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(n), 32'(e.lat));
    check({name, " err"}, 32'(bus_if.err_out), 32'(e.err));
    check({name, " valid"}, 32'(bus_if.pattern_valid_out), 32'(e.valid));
    check({name, " pattern"}, 32'(bus_if.pattern_out), 32'(e.pat));
    check({name, " valid_low_while_busy"}, 32'(valid_low), 32'd1);
    if (e.valid) begin
      check({name, " balls"}, 32'(bus_if.num_balls_out), 32'(e.balls));
      check({name, " len"}, 32'(bus_if.pattern_len_out), 32'(e.len));
    end
    @(posedge clk_in); #1;
    check({name, " done_pulse"}, 32'(bus_if.done_out), 32'd0);
  endtask

  initial begin
    int p[7];
    bit done_seen;
    bus_if.pattern_in = '0;
    bus_if.len_in     = '0;
    bus_if.start_in   = 1'b0;
    rst_in            = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst busy", 32'(bus_if.busy_out), 32'd0);
    check("rst done", 32'(bus_if.done_out), 32'd0);
    check("rst valid", 32'(bus_if.pattern_valid_out), 32'd0);
    check("rst err", 32'(bus_if.err_out), 32'd0);
    check("rst pattern", 32'(bus_if.pattern_out), 32'd0);
    check("rst len", 32'(bus_if.pattern_len_out), 32'd0);
    check("rst balls", 32'(bus_if.num_balls_out), 32'd0);

    // start_in coincident with reset is dropped
    @(negedge clk_in);
    bus_if.pattern_in = 21'o0000135;
    bus_if.len_in     = 3'd3;
    bus_if.start_in   = 1'b1;
    @(posedge clk_in); #1;
    check("rst_start busy", 32'(bus_if.busy_out), 32'd0);
    @(negedge clk_in);
    bus_if.start_in = 1'b0;
    rst_in          = 1'b0;
    @(posedge clk_in); #1;
    check("rst_start idle", 32'(bus_if.busy_out), 32'd0);

    p = '{3, 5, 5, 5, 5, 5, 5}; run("p3", p, 1, -1);
    p = '{1, 5, 3, 0, 0, 0, 0}; run("p153", p, 3, -1);
    p = '{5, 3, 1, 0, 0, 0, 0}; run("p531", p, 3, -1);
    p = '{5, 4, 0, 0, 0, 0, 0}; run("p54", p, 2, -1);
    p = '{0, 0, 0, 0, 0, 0, 0}; run("p000", p, 3, -1);
    p = '{3, 3, 3, 0, 0, 0, 0}; run("len0", p, 0, -1);
    p = '{4, 3, 2, 0, 0, 0, 0}; run("p432", p, 3, -1);
    p = '{7, 7, 7, 7, 7, 7, 7}; run("p7x7", p, 7, -1);
    p = '{7, 5, 3, 1, 0, 0, 0}; run("p7531", p, 4, -1);
    p = '{4, 4, 1, 3, 0, 0, 0}; run("p4413", p, 4, -1);
    p = '{5, 3, 1, 0, 0, 0, 0}; run("p531_glitch", p, 3, 8);

    // Reset during CHECK aborts the run silently
    @(negedge clk_in);
    bus_if.pattern_in = 21'o0000135;
    bus_if.len_in     = 3'd3;
    bus_if.start_in   = 1'b1;
    @(posedge clk_in); #1;
    bus_if.start_in = 1'b0;
    repeat (8) @(posedge clk_in);
    #1;
    check("rst_mid busy_before", 32'(bus_if.busy_out), 32'd1);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check("rst_mid busy", 32'(bus_if.busy_out), 32'd0);
    check("rst_mid done", 32'(bus_if.done_out), 32'd0);
    check("rst_mid valid", 32'(bus_if.pattern_valid_out), 32'd0);
    check("rst_mid err", 32'(bus_if.err_out), 32'd0);
    check("rst_mid pattern", 32'(bus_if.pattern_out), 32'd0);
    check("rst_mid len", 32'(bus_if.pattern_len_out), 32'd0);
    check("rst_mid balls", 32'(bus_if.num_balls_out), 32'd0);
    @(negedge clk_in);
    rst_in    = 1'b0;
    done_seen = 1'b0;
    repeat (20) begin
      @(posedge clk_in); #1;
      if (bus_if.done_out) done_seen = 1'b1;
    end
    check("rst_mid no_done", 32'(done_seen), 32'd0);

    p = '{3, 0, 0, 0, 0, 0, 0}; run("p3_after_rst", p, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/siteswap_validator.md
Name: siteswap_validator

Overview:
- Upstream stage of the trajectory generator. Accepts a raw siteswap juggling pattern from user-input logic (switch or UART decoder).
- Checks that the pattern is juggleable: integer average and no two throws landing on the same beat.
- Derives the ball count and presents `pattern_out`, `num_balls_out` and `pattern_valid_out` in the form the trajectory generator consumes.
- Processes one throw per cycle; sequential by design, so no wide combinational checks.

Parameters:
- MAX_LEN, 7, maximum pattern period; also the width of the pattern arrays.
- MAX_BALLS, 7, largest accepted ball count; a larger average raises ERR_TOO_MANY.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- pattern_in  input  3 x [MAX_LEN-1:0]  raw throw heights, index 0 thrown first
- len_in  input  3  pattern period, 1..MAX_LEN valid
- start_in  input  1  one-cycle request to validate `pattern_in`/`len_in`
- busy_out  output  1  high while validating
- done_out  output  1  one-cycle pulse when validation finishes, pass or fail
- pattern_out  output  3 x [MAX_LEN-1:0]  validated pattern, entries >= len zero-filled
- pattern_len_out  output  3  validated period
- num_balls_out  output  3  sum/len
- pattern_valid_out  output  1  level; high while a validated pattern is held
- err_out  output  3  err_e code, meaningful after `done_out`

Behaviour:
- Reset (synchronous, active-high, one clock, one synchronous reset): state IDLE; every output 0; internal accumulators, occupancy bitmap and latched pattern cleared. Reset in any state, including mid-CHECK, aborts the run with no `done_out`.
- States: IDLE, SUM, DIV, CHECK, DONE, ERROR.
- `start_in` is sampled only in IDLE, DONE or ERROR; it is ignored while `busy_out` is high. On acceptance:
  - latch pattern and length;
  - clear `pattern_valid_out`, `err_out`, `pattern_out`;
  - `busy_out` goes high next cycle.
- Bad length: `len_in` = 0 or > MAX_LEN goes straight to ERROR with ERR_LEN. `done_out` pulses the cycle after the start edge.
- SUM: `len` cycles, one index per cycle. Accumulate 6-bit sum (max 49).
- DIV: repeated subtraction of `len` from the remainder.
  - Each cycle with remainder >= len: subtract and increment quotient.
  - First cycle with remainder < len: evaluate. SUM+DIV = q+1 cycles of DIV.
  - Remainder != 0 -> ERR_NOT_INT.
  - q = 0 -> ERR_ZERO.
  - q > MAX_BALLS -> ERR_TOO_MANY.
  - Otherwise -> CHECK.
- CHECK: index i = 0..len-1, one per cycle.
  - land = (i + p[i]) mod len, computed combinationally in sub-module landing_mod; operand <= 13.
  - Bitmap bit already set -> ERROR with ERR_COLLIDE the next cycle.
  - Otherwise set the bit.
  - After index len-1 -> DONE.
- DONE: `done_out` pulses on entry. Then `pattern_valid_out` = 1 and `err_out` = ERR_NONE, with outputs held until the next accepted start.
- ERROR: `done_out` pulses on entry. `err_out` holds the code; `pattern_valid_out` = 0; `pattern_out` = 0.
- Latency on pass: with the accepting edge counted as 0, `done_out` is high in the cycle after edge 2*len+q+1.
- `start_in` coincident with reset: reset wins.

Optional Feature:
- Macro: SITESWAP_ROTATE_EN.
- When defined: after CHECK, a ROTATE state scans len cycles for the first index of the maximum throw. `pattern_out` is emitted rotated so that throw sits at index 0, e.g. "153" becomes "531". Latency grows by len cycles.
- When undefined: pattern is emitted in input order, and the ROTATE state and its logic are absent.

Decomposition:
- Shared package juggle_pkg holds:
  - MAX_LEN_C = 7;
  - typedef throw_t = logic [2:0];
  - enum err_e {ERR_NONE=0, ERR_LEN=1, ERR_NOT_INT=2, ERR_ZERO=3, ERR_COLLIDE=4, ERR_TOO_MANY=5}.
  - The trajectory generator imports throw_t from the same package.
- One sub-module, landing_mod: purely combinational (a + b) mod len for a < 7, b < 8, 1 <= len <= 7, built as an unrolled conditional-subtract chain.

Test Plan:
- "3", len 1 -> num_balls 3, pattern_out = {3,0,0,0,0,0,0}, `done_out` high after edge 6, `pattern_valid_out` = 1.
- "531", len 3 -> landings 2,1,0, num_balls 3, `done_out` after edge 10. With SITESWAP_ROTATE_EN: input "153" -> pattern_out "531".
- "432", len 3 -> ERR_COLLIDE at index 1, `pattern_valid_out` = 0, pattern_out all 0.
- "54", len 2 -> ERR_NOT_INT. "000", len 3 -> ERR_ZERO. len 0 -> ERR_LEN with `done_out` the cycle after start.
- Start "531", pulse `start_in` again during CHECK -> ignored, result unchanged. Assert `rst_in` mid-CHECK -> all outputs 0 next cycle, no `done_out`.
- Validate "531" then start "54" -> `pattern_valid_out` drops the cycle after acceptance and stays 0, `err_out` = ERR_NOT_INT.
